exception_addr_seq: RTL and testbench

EXCEPTION_ADDR_SEQ -- requirements
Module: exception_addr_seq

---
 rtl/exception_addr_seq_pkg.sv | 77 +++++++
 rtl/exception_addr_seq.sv | 171 +++++++++++++++++
 tb/tb_exception_addr_seq.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/exception_addr_seq_pkg.sv
// Shared definitions for the exception address sequencer and main control.
// Holds the sequencer state encoding, the exception cause encoding, the
// address-mux selector constants for the three exception vectors, and small
// helpers for mapping causes to selectors and clamping selector values.
package exception_addr_seq_pkg;

    // Sequencer state encoding (kept as plain constants so legacy main-control
    // code can compare against the same values).
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SAVE_EPC = 3'd1;
    localparam logic [2:0] ST_FETCH    = 3'd2;
    localparam logic [2:0] ST_WAIT     = 3'd3;
    localparam logic [2:0] ST_LOAD     = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_OPCODE   = 2'd1,
        CAUSE_OVERFLOW = 2'd2,
        CAUSE_DIVZERO  = 2'd3
    } cause_e;

    // Address-mux selectors. 3'b000 routes the PC (used while saving EPC);
    // the vector selectors point at the handler bytes 253/254/255.
    localparam logic [2:0] SEL_PC       = 3'b000;
    localparam logic [2:0] VEC_OPCODE   = 3'b010;
    localparam logic [2:0] VEC_OVERFLOW = 3'b011;
    localparam logic [2:0] VEC_DIVZERO  = 3'b100;
    localparam logic [2:0] SEL_MAX      = 3'b100;

    // Request/pending vectors are packed {opcode, overflow, divzero}, so the
    // most significant set bit is always the highest-priority cause.
    localparam int REQ_OPCODE   = 2;
    localparam int REQ_OVERFLOW = 1;
    localparam int REQ_DIVZERO  = 0;

    function automatic logic [2:0] cause_vector(input cause_e c);
        logic [2:0] v;
        case (c)
            CAUSE_OPCODE:   v = VEC_OPCODE;
            CAUSE_OVERFLOW: v = VEC_OVERFLOW;
            CAUSE_DIVZERO:  v = VEC_DIVZERO;
            default:        v = SEL_PC;
        endcase
        return v;
    endfunction

    function automatic cause_e highest_cause(input logic [2:0] req);
        cause_e c;
        if (req[REQ_OPCODE])
            c = CAUSE_OPCODE;
        else if (req[REQ_OVERFLOW])
            c = CAUSE_OVERFLOW;
        else if (req[REQ_DIVZERO])
            c = CAUSE_DIVZERO;
        else
            c = CAUSE_NONE;
        return c;
    endfunction

    function automatic logic [2:0] cause_mask(input cause_e c);
        logic [2:0] m;
        case (c)
            CAUSE_OPCODE:   m = 3'b100;
            CAUSE_OVERFLOW: m = 3'b010;
            CAUSE_DIVZERO:  m = 3'b001;
            default:        m = 3'b000;
        endcase
        return m;
    endfunction

    // Selector values above the divzero vector do not exist on the mux.
    function automatic logic [2:0] clamp_sel(input logic [2:0] s);
        return (s > SEL_MAX) ? SEL_PC : s;
    endfunction

endpackage

// File: rtl/exception_addr_seq.sv
// Exception address sequencer.
// On an exception it takes over the address mux from main control, saves the
// EPC, reads the handler address byte from the exception vector, loads it into
// the PC, acknowledges, and hands the mux back. Exceptions arriving while a
// handler entry is in progress are queued and serviced back-to-back.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   ctrl_addr_sel address-mux selector requested by main control
//   exc_opcode    invalid-opcode exception pulse    (highest priority)
//   exc_overflow  arithmetic-overflow exception pulse
//   exc_divzero   divide-by-zero exception pulse     (lowest priority)
//   addr_sel      selector driven to the address mux (never 3'b101..3'b111)
//   mem_read      memory read strobe
//   epc_write     EPC register write enable
//   pc_load_byte  PC <= zero-extended memory byte
//   busy          sequencer owns the address mux; main control stalled
//   exc_ack       one-cycle pulse on handler entry
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | main control owns the mux; watching for exceptions
// SAVE_EPC | write current PC into EPC (addr_sel = PC)
// FETCH    | issue the vector byte read, load the latency counter
// WAIT     | hold the vector address for MEM_LAT cycles
// LOAD     | load the returned byte into the PC
// DONE     | acknowledge; start the next pending cause or return to IDLE
module exception_addr_seq
    import exception_addr_seq_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] ctrl_addr_sel,
    input  logic       exc_opcode,
    input  logic       exc_overflow,
    input  logic       exc_divzero,
    output logic [2:0] addr_sel,
    output logic       mem_read,
    output logic       epc_write,
    output logic       pc_load_byte,
    output logic       busy,
    output logic       exc_ack
);

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_LAT - 1);

    logic [2:0] state, state_nxt;
    cause_e     cause, cause_nxt;
    logic [2:0] pending, pending_nxt;
    logic [2:0] wait_cnt, wait_cnt_nxt;
    logic [2:0] exc_req;
    logic [2:0] done_req;
    logic [2:0] vector_sel;

    assign exc_req    = {exc_opcode, exc_overflow, exc_divzero};
    assign vector_sel = cause_vector(cause);
    // In DONE a pulse arriving this very cycle competes with the queue.
    assign done_req   = pending | exc_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cause    <= CAUSE_NONE;
            pending  <= 3'b000;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            cause    <= cause_nxt;
            pending  <= pending_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cause_nxt    = cause;
        pending_nxt  = pending;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (|exc_req) begin
                    cause_nxt   = highest_cause(exc_req);
                    // lower-priority causes in the same cycle are not lost
                    pending_nxt = pending | (exc_req & ~cause_mask(highest_cause(exc_req)));
                    state_nxt   = ST_SAVE_EPC;
                end
            end
            ST_SAVE_EPC: begin
                pending_nxt = pending | exc_req;
                state_nxt   = ST_FETCH;
            end
            ST_FETCH: begin
                pending_nxt  = pending | exc_req;
                wait_cnt_nxt = WAIT_LOAD;
                state_nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                pending_nxt = pending | exc_req;
                if (wait_cnt == 3'd0)
                    state_nxt = ST_LOAD;
                else
                    wait_cnt_nxt = wait_cnt - 3'd1;
            end
            ST_LOAD: begin
                pending_nxt = pending | exc_req;
                state_nxt   = ST_DONE;
            end
            ST_DONE: begin
                if (|done_req) begin
                    // skip IDLE so main control never sees the mux in between
                    cause_nxt   = highest_cause(done_req);
                    pending_nxt = done_req & ~cause_mask(highest_cause(done_req));
                    state_nxt   = ST_SAVE_EPC;
                end else begin
                    cause_nxt   = CAUSE_NONE;
                    pending_nxt = 3'b000;
                    state_nxt   = ST_IDLE;
                end
            end
            default: begin
                cause_nxt   = CAUSE_NONE;
                pending_nxt = 3'b000;
                state_nxt   = ST_IDLE;
            end
        endcase
    end

    // Outputs decode straight from state so an asynchronous reset silences
    // every strobe immediately.
    always_comb begin
        addr_sel     = SEL_PC;
        mem_read     = 1'b0;
        epc_write    = 1'b0;
        pc_load_byte = 1'b0;
        busy         = 1'b1;
        exc_ack      = 1'b0;
        case (state)
            ST_IDLE: begin
                addr_sel = clamp_sel(ctrl_addr_sel);
                busy     = 1'b0;
            end
            ST_SAVE_EPC: begin
                addr_sel  = SEL_PC;
                epc_write = 1'b1;
            end
            ST_FETCH: begin
                addr_sel = vector_sel;
                mem_read = 1'b1;
            end
            ST_WAIT: begin
                addr_sel = vector_sel;
            end
            ST_LOAD: begin
                addr_sel     = vector_sel;
                pc_load_byte = 1'b1;
            end
            ST_DONE: begin
                addr_sel = SEL_PC;
                exc_ack  = 1'b1;
            end
            default: begin
                addr_sel = clamp_sel(ctrl_addr_sel);
                busy     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_exception_addr_seq.sv
module tb_exception_addr_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] ctrl_addr_sel = 3'b000;
    logic       exc_opcode = 1'b0;
    logic       exc_overflow = 1'b0;
    logic       exc_divzero = 1'b0;

    logic [2:0] addr_sel2, addr_sel1, addr_sel7;
    logic       mem_read2, mem_read1, mem_read7;
    logic       epc_write2, epc_write1, epc_write7;
    logic       pc_load_byte2, pc_load_byte1, pc_load_byte7;
    logic       busy2, busy1, busy7;
    logic       exc_ack2, exc_ack1, exc_ack7;

    always #5 clk = ~clk;

    exception_addr_seq #(.MEM_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .ctrl_addr_sel(ctrl_addr_sel),
        .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_divzero(exc_divzero),
        .addr_sel(addr_sel2), .mem_read(mem_read2), .epc_write(epc_write2),
        .pc_load_byte(pc_load_byte2), .busy(busy2), .exc_ack(exc_ack2));

    exception_addr_seq #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .ctrl_addr_sel(ctrl_addr_sel),
        .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_divzero(exc_divzero),
        .addr_sel(addr_sel1), .mem_read(mem_read1), .epc_write(epc_write1),
        .pc_load_byte(pc_load_byte1), .busy(busy1), .exc_ack(exc_ack1));

    exception_addr_seq #(.MEM_LAT(7)) dut7 (
        .clk(clk), .reset(reset), .ctrl_addr_sel(ctrl_addr_sel),
        .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_divzero(exc_divzero),
        .addr_sel(addr_sel7), .mem_read(mem_read7), .epc_write(epc_write7),
        .pc_load_byte(pc_load_byte7), .busy(busy7), .exc_ack(exc_ack7));

    // {addr_sel, busy, mem_read, epc_write, pc_load_byte, exc_ack}
    logic [7:0] out2;
    assign out2 = {addr_sel2, busy2, mem_read2, epc_write2, pc_load_byte2, exc_ack2};

    int vectors = 0;
    int miscompares = 0;

    // Reference model for MEM_LAT=2: a handler entry is a run of L+4 cycles
    // indexed by k; exceptions are a set of pending causes (bit2 opcode,
    // bit1 overflow, bit0 divzero).
    localparam int L = 2;
    bit       m_active;
    int       m_k;
    int       m_cur;
    bit [2:0] m_pend;

    logic last_pl1, last_pl7;

    function automatic logic [2:0] vec_of(input int c);
        if (c == 2) return 3'b010;
        if (c == 1) return 3'b011;
        return 3'b100;
    endfunction

    function automatic int top_bit(input bit [2:0] v);
        if (v[2]) return 2;
        if (v[1]) return 1;
        return 0;
    endfunction

    function automatic logic [7:0] model_out(input logic [2:0] ctrl);
        logic [2:0] sel;
        if (!m_active) begin
            sel = (ctrl > 3'd4) ? 3'b000 : ctrl;
            return {sel, 5'b00000};
        end
        sel = (m_k >= 1 && m_k <= L + 2) ? vec_of(m_cur) : 3'b000;
        return {sel, 1'b1, (m_k == 1), (m_k == 0), (m_k == L + 2), (m_k == L + 3)};
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_k      = 0;
        m_cur    = 0;
        m_pend   = 3'b000;
    endtask

    task automatic model_update(input bit [2:0] ex);
        if (!m_active) begin
            if (ex != 3'b000) begin
                m_cur    = top_bit(ex);
                m_pend   = ex;
                m_pend[m_cur] = 1'b0;
                m_active = 1'b1;
                m_k      = 0;
            end
        end else begin
            m_pend = m_pend | ex;
            if (m_k == L + 3) begin
                if (m_pend != 3'b000) begin
                    m_cur = top_bit(m_pend);
                    m_pend[m_cur] = 1'b0;
                    m_k = 0;
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_k = m_k + 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b (addr_sel,busy,mem_read,epc_write,pc_load_byte,exc_ack)",
                     name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One cycle: drive after the falling edge, compare mid-cycle, advance the
    // model at the rising edge, return at the next falling edge.
    task automatic step(input logic [2:0] ctrl, input bit [2:0] ex, input string name,
                        output logic [7:0] seen);
        ctrl_addr_sel = ctrl;
        {exc_opcode, exc_overflow, exc_divzero} = ex;
        #1;
        seen     = out2;
        last_pl1 = pc_load_byte1;
        last_pl7 = pc_load_byte7;
        check(name, out2, model_out(ctrl));
        @(posedge clk);
        model_update(ex);
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0] ctrl;
        logic [2:0] exp_sel;
    } sweep_t;

    typedef struct {
        bit [2:0]   ex;
        logic [7:0] exp;
    } seq_t;

    sweep_t sweep_tab[8];
    seq_t   ovf_tab[8];

    initial begin
        logic [7:0] seen;
        int first1, first7;
        int n_epc, n_mem, n_ack, n_gap, n_pl;
        logic [2:0] sels[2];

        for (int i = 0; i < 8; i++) begin
            sweep_tab[i].ctrl    = 3'(i);
            sweep_tab[i].exp_sel = (i <= 4) ? 3'(i) : 3'b000;
        end
        ovf_tab[0] = '{3'b010, {3'b001, 5'b00000}};
        ovf_tab[1] = '{3'b000, {3'b000, 5'b10100}};
        ovf_tab[2] = '{3'b000, {3'b011, 5'b11000}};
        ovf_tab[3] = '{3'b000, {3'b011, 5'b10000}};
        ovf_tab[4] = '{3'b000, {3'b011, 5'b10000}};
        ovf_tab[5] = '{3'b000, {3'b011, 5'b10010}};
        ovf_tab[6] = '{3'b000, {3'b000, 5'b10001}};
        ovf_tab[7] = '{3'b000, {3'b001, 5'b00000}};

        // Reset held low with exceptions asserted: nothing may start.
        model_reset();
        ctrl_addr_sel = 3'b110;
        {exc_opcode, exc_overflow, exc_divzero} = 3'b111;
        #22;
        check("reset_clamp", out2, {3'b000, 5'b00000});
        ctrl_addr_sel = 3'b011;
        #1;
        check("reset_pass", out2, {3'b011, 5'b00000});
        {exc_opcode, exc_overflow, exc_divzero} = 3'b000;
        @(negedge clk);
        reset = 1'b1;

        // Idle selector sweep.
        for (int i = 0; i < 8; i++) begin
            step(sweep_tab[i].ctrl, 3'b000, "idle_model", seen);
            check("idle_sweep", seen, {sweep_tab[i].exp_sel, 5'b00000});
        end

        // Overflow run; MEM_LAT=1 and 7 instances watched alongside.
        first1 = -1;
        first7 = -1;
        for (int c = 0; c < 13; c++) begin
            step(3'b001, (c < 8) ? ovf_tab[c].ex : 3'b000, "ovf_model", seen);
            if (c < 8) check("ovf_table", seen, ovf_tab[c].exp);
            if (last_pl1 && first1 < 0) first1 = c;
            if (last_pl7 && first7 < 0) first7 = c;
        end
        check_int("lat1_pc_load_cycle", first1, 4);
        check_int("lat7_pc_load_cycle", first7, 10);

        // Opcode and divzero together: serviced back-to-back.
        n_epc = 0; n_mem = 0; n_ack = 0; n_gap = 0;
        sels[0] = 3'b000; sels[1] = 3'b000;
        for (int c = 0; c < 14; c++) begin
            step(3'b010, (c == 0) ? 3'b101 : 3'b000, "dual_model", seen);
            if (seen[3]) begin
                if (n_mem < 2) sels[n_mem] = seen[7:5];
                n_mem++;
            end
            if (seen[2]) n_epc++;
            if (seen[0]) n_ack++;
            if (c >= 1 && c <= 12 && !seen[4]) n_gap++;
        end
        check_int("dual_epc_count", n_epc, 2);
        check_int("dual_ack_count", n_ack, 2);
        check_int("dual_first_vec", int'(sels[0]), 2);
        check_int("dual_second_vec", int'(sels[1]), 4);
        check_int("dual_idle_gap", n_gap, 0);

        // Overflow during the WAIT of a divzero entry.
        n_mem = 0; n_ack = 0;
        sels[0] = 3'b000; sels[1] = 3'b000;
        for (int c = 0; c < 14; c++) begin
            step(3'b000, (c == 0) ? 3'b001 : ((c == 3) ? 3'b010 : 3'b000), "queued_model", seen);
            if (seen[3]) begin
                if (n_mem < 2) sels[n_mem] = seen[7:5];
                n_mem++;
            end
            if (seen[0]) n_ack++;
        end
        check_int("queued_read_count", n_mem, 2);
        check_int("queued_ack_count", n_ack, 2);
        check_int("queued_first_vec", int'(sels[0]), 4);
        check_int("queued_second_vec", int'(sels[1]), 3);

        // Reset in the middle of WAIT.
        for (int c = 0; c < 3; c++)
            step(3'b001, (c == 0) ? 3'b010 : 3'b000, "abort_model", seen);
        #1;
        reset = 1'b0;
        #1;
        check("abort_immediate", out2, {3'b001, 5'b00000});
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        n_pl = 0;
        for (int c = 0; c < 8; c++) begin
            step(3'b001, 3'b000, "abort_after", seen);
            if (seen[1]) n_pl++;
        end
        check_int("abort_no_pc_load", n_pl, 0);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            bit [2:0] ex;
            ex[2] = ($urandom_range(0, 11) == 0);
            ex[1] = ($urandom_range(0, 11) == 0);
            ex[0] = ($urandom_range(0, 11) == 0);
            step(3'($urandom_range(0, 7)), ex, "random", seen);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
